// File: rtl/aucohl_uart_tx.sv
// aucohl_uart_tx: UART transmitter that pops words from a FIFO and sends
// start, data (LSB first), optional parity and one or two stop bits.
// Each bit lasts 16 prescaler ticks; a tick is emitted every baud_div+1 clocks.
module aucohl_uart_tx #(
    parameter int MDW  = 9,
    parameter int DIVW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [DIVW-1:0] baud_div,
    input  logic [3:0]      data_size,
    input  logic            stop2,
    input  logic [2:0]      parity_type,
    input  logic            fifo_empty,
    input  logic [MDW-1:0]  fifo_rdata,
    output logic            fifo_rd,
    output logic            tx,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          r_state;
    logic [DIVW-1:0] r_presc;
    logic [3:0]      r_tick;
    logic [MDW-1:0]  r_shift;
    logic [3:0]      r_bit;
    logic            r_par;
    logic            r_stop_cnt;
    logic            r_tx;
    logic            r_busy;
    logic            r_done;

    logic            w_pop;
    logic            w_tick;
    logic            w_bit_end;
    logic [DIVW-1:0] w_presc_nxt;
    logic [3:0]      w_tick_nxt;
    logic            w_pre_end;
    logic [3:0]      w_n;
    logic            w_par_en;
    logic            w_par_bit;
    logic            w_last_stop;

    // Pop qualifier: only from IDLE, and forced low while reset is held.
    assign w_pop   = (r_state == S_IDLE) && en && !fifo_empty;
    assign fifo_rd = w_pop && rst_n;

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

    assign w_tick      = (r_presc == baud_div);
    assign w_bit_end   = w_tick && (r_tick == 4'hF);
    assign w_presc_nxt = w_tick ? '0 : r_presc + DIVW'(1);
    assign w_tick_nxt  = w_tick ? r_tick + 4'd1 : r_tick;
    // True when the coming cycle will be the last cycle of the current bit;
    // lets done be registered yet line up with the final stop-bit cycle.
    assign w_pre_end   = (w_presc_nxt == baud_div) && (w_tick_nxt == 4'hF);

    assign w_n = (data_size < 4'd5) ? 4'd5 :
                 (data_size > 4'd9) ? 4'd9 : data_size;

    assign w_last_stop = !stop2 || r_stop_cnt;

    // Parity decode; r_par holds the XOR of the data bits already sent.
    always_comb begin
        w_par_en  = 1'b1;
        w_par_bit = 1'b0;
        case (parity_type)
            3'b001:  w_par_bit = ~r_par;
            3'b010:  w_par_bit = r_par;
            3'b100:  w_par_bit = 1'b0;
            3'b101:  w_par_bit = 1'b1;
            default: w_par_en  = 1'b0;
        endcase
    end

    // Frame sequencer with registered line, busy and done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_tick     <= '0;
            r_shift    <= '0;
            r_bit      <= '0;
            r_par      <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_presc <= w_presc_nxt;
                r_tick  <= w_tick_nxt;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift    <= fifo_rdata;
                        r_presc    <= '0;
                        r_tick     <= '0;
                        r_bit      <= '0;
                        r_par      <= 1'b0;
                        r_stop_cnt <= 1'b0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_par   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == w_n - 4'd1) begin
                            r_stop_cnt <= 1'b0;
                            if (w_par_en) begin
                                r_tx    <= w_par_bit;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_tx    <= r_shift[0];
                            r_par   <= r_par ^ r_shift[0];
                            r_shift <= r_shift >> 1;
                            r_bit   <= r_bit + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (w_last_stop) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end else begin
                        r_done <= w_last_stop && w_pre_end;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aucohl_uart_tx.sv
// Scoreboard bench for aucohl_uart_tx: expected frames are queued as words
// are pushed into the FIFO model; a monitor checks every line cycle.
module tb_aucohl_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] baud_div = '0;
    logic [3:0]  data_size = 4'd8;
    logic        stop2 = 1'b0;
    logic [2:0]  parity_type = 3'b000;
    logic        fifo_empty = 1'b1;
    logic [8:0]  fifo_rdata = '0;
    logic        fifo_rd;
    logic        tx;
    logic        busy;
    logic        done;

    aucohl_uart_tx #(.MDW(9), .DIVW(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .baud_div(baud_div),
        .data_size(data_size), .stop2(stop2), .parity_type(parity_type),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] bits;
        int          nbits;
        int          bper;
    } frame_t;

    frame_t     exp_q[$];
    logic [8:0] fq[$];
    int         starts[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         n_frames = 0;
    int         n_pops = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame built from the current configuration.
    function automatic frame_t make_frame(input logic [8:0] w);
        frame_t f;
        int n, ones, k;
        n = (data_size < 5) ? 5 : (data_size > 9) ? 9 : int'(data_size);
        f.bits = '0;
        f.bits[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            f.bits[1 + i] = w[i];
            ones += int'(w[i]);
        end
        k = 1 + n;
        case (parity_type)
            3'b001: begin f.bits[k] = (ones % 2 == 0); k++; end
            3'b010: begin f.bits[k] = (ones % 2 == 1); k++; end
            3'b100: begin f.bits[k] = 1'b0; k++; end
            3'b101: begin f.bits[k] = 1'b1; k++; end
            default: ;
        endcase
        f.bits[k] = 1'b1; k++;
        if (stop2) begin f.bits[k] = 1'b1; k++; end
        f.nbits = k;
        f.bper  = 16 * (int'(baud_div) + 1);
        return f;
    endfunction

    function automatic void fifo_upd();
        fifo_empty = (fq.size() == 0);
        fifo_rdata = fifo_empty ? 9'd0 : fq[0];
    endfunction

    task automatic push_word(input logic [8:0] w);
        fq.push_back(w);
        exp_q.push_back(make_frame(w));
        fifo_upd();
    endtask

    task automatic cfg(input int d, input int ds, input int s2, input int pt);
        baud_div    = 16'(d);
        data_size   = 4'(ds);
        stop2       = 1'(s2);
        parity_type = 3'(pt);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k;
        k = 0;
        while (n_frames < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("frames_done", 32'(n_frames >= target), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // FIFO model: pops the head one edge after the DUT strobes fifo_rd.
    initial begin : fifo_model
        bit p;
        forever begin
            @(negedge clk);
            p = fifo_rd;
            @(posedge clk);
            #1;
            if (p && rst_n) begin
                if (fq.size() > 0) void'(fq.pop_front());
                n_pops++;
                fifo_upd();
            end
        end
    end

    // Monitor: on each pop, checks the whole frame cycle by cycle.
    initial begin : monitor
        frame_t f;
        int     len, first;
        bit     bad_tx, bad_done, bad_busy, bad_rd, aborted;
        logic   exp_bit, got_bit;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fifo_rd) begin
                    check("pop_nonempty", 32'(fifo_empty), 32'd0);
                    check("pop_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        f = exp_q.pop_front();
                        starts.push_back(cyc);
                        len = f.nbits * f.bper;
                        bad_tx = 0; bad_done = 0; bad_busy = 0; bad_rd = 0; aborted = 0;
                        first = 0; exp_bit = 1'b0; got_bit = 1'b0;
                        for (int c = 0; c < len; c++) begin
                            @(negedge clk);
                            if (!rst_n) begin
                                aborted = 1;
                                break;
                            end
                            if (tx !== f.bits[c / f.bper] && !bad_tx) begin
                                bad_tx = 1; first = c; got_bit = tx; exp_bit = f.bits[c / f.bper];
                            end
                            if (done !== (c == len - 1)) bad_done = 1;
                            if (busy !== 1'b1) bad_busy = 1;
                            if (fifo_rd !== 1'b0) bad_rd = 1;
                        end
                        if (!aborted) begin
                            n_vec++;
                            if (bad_tx) begin
                                n_err++;
                                $display("FAIL frame_tx: bit cycle %0d got %b want %b", first, got_bit, exp_bit);
                            end
                            check("frame_done_pulse", 32'(bad_done), 32'd0);
                            check("frame_busy", 32'(bad_busy), 32'd0);
                            check("frame_no_repop", 32'(bad_rd), 32'd0);
                            n_frames++;
                        end
                    end
                end else begin
                    check("idle_line", {29'd0, tx, busy, done}, 32'b100);
                end
            end
        end
    end

    initial begin : stimulus
        int base, pops0, fr0, flen;
        frame_t t;
        fifo_upd();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 8N1, 0x55
        cfg(0, 8, 0, 0);
        push_word(9'h055);
        en = 1'b1;
        wait_frames(1, 2000);

        // 8E1 at baud_div=3, 0xA3
        cfg(3, 8, 0, 2);
        push_word(9'h0A3);
        wait_frames(2, 2000);

        // 7O2, bit 8 set in the word must be ignored
        cfg(0, 7, 1, 1);
        push_word(9'h17F);
        wait_frames(3, 2000);

        // Three words back-to-back, one idle clock between frames
        cfg(1, 6, 0, 5);
        base = starts.size();
        push_word(9'h015);
        push_word(9'h02A);
        push_word(9'h133);
        wait_frames(6, 6000);
        t = make_frame(9'h000);
        flen = t.nbits * t.bper;
        for (int i = 0; i < 2; i++)
            if (starts.size() > base + i + 1)
                check("b2b_gap", 32'(starts[base + i + 1] - starts[base + i]), 32'(flen + 1));

        // en dropped during DATA of the first frame
        cfg(0, 8, 0, 0);
        pops0 = n_pops;
        fr0 = n_frames;
        push_word(9'h0C1);
        push_word(9'h0C2);
        push_word(9'h0C3);
        repeat (16 * 3) @(posedge clk);
        #1;
        en = 1'b0;
        wait_frames(fr0 + 1, 2000);
        repeat (300) @(posedge clk);
        #1;
        check("endrop_pops", 32'(n_pops - pops0), 32'd1);
        check("endrop_left", 32'(fq.size()), 32'd2);
        check("endrop_tx", 32'(tx), 32'd1);
        fq.delete();
        exp_q.delete();
        fifo_upd();

        // Asynchronous reset mid-DATA with data still queued
        fr0 = n_frames;
        push_word(9'h0F0);
        push_word(9'h00F);
        en = 1'b1;
        repeat (16 * 4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tx", 32'(tx), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        fq.delete();
        exp_q.delete();
        fifo_upd();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("arst_no_frame", 32'(n_frames), 32'(fr0));
        check("arst_idle_tx", 32'(tx), 32'd1);
        check("arst_idle_busy", 32'(busy), 32'd0);

        // Randomized configurations, including out-of-range data_size
        for (int k = 0; k < 8; k++) begin
            fr0 = n_frames;
            cfg(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            push_word(9'($urandom));
            if (k % 3 == 0) begin
                push_word(9'($urandom));
                wait_frames(fr0 + 2, 4000);
            end else begin
                wait_frames(fr0 + 1, 2000);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aucohl_uart_tx.md
# aucohl_uart_tx

Serial UART transmitter that drains a byte FIFO: it is the reader on the FIFO's rd/empty/rdata interface and the serial driver of the TX line. It pops one word per frame, serialises start, data (LSB first), optional parity and stop bits, and reports completion. Bit timing uses 16 ticks per bit, so its bit period matches a 16x-oversampling receiver on the same divisor.

## Interface
- MDW, 9: maximum data width; FIFO word width.
- DIVW, 16: baud divisor width.
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- en  in  1  transmitter enable; sampled only in IDLE.
- baud_div  in  DIVW  tick every baud_div+1 clk cycles.
- data_size  in  4  data bits per frame, 5..9.
- stop2  in  1  0 = one stop bit, 1 = two stop bits.
- parity_type  in  3  000 none, 001 odd, 010 even, 100 stick-0, 101 stick-1; other values = none.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  MDW  FIFO head word, valid while fifo_empty=0.
- fifo_rd  out  1  one-cycle pop strobe.
- tx  out  1  serial line, idle high.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at end of last stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: if en=1 and fifo_empty=0, assert fifo_rd for that cycle, latch fifo_rdata into shift register, clear prescaler and tick counter, go START. Otherwise stay; fifo_rd=0.
- Prescaler: counts 0..baud_div and emits a tick on the wrap; baud_div=0 gives a tick every cycle. A 4-bit tick counter marks a bit end after 16 ticks.
- START: tx=0 for one bit, then DATA.
- DATA: tx=shift[0] and shift right at each bit end. Bit counter runs 0..N-1, where N = data_size clamped to 5..9 (<5 -> 5, >9 -> 9). After N bits: PARITY if parity enabled, else STOP.
- PARITY: odd = ~^(N data bits); even = ^(N data bits); stick-0 = 0; stick-1 = 1. Lasts one bit, then STOP.
- STOP: tx=1 for 1 bit (stop2=0) or 2 bits (stop2=1). At the end: done=1 for one cycle, return IDLE.
- Back-to-back: in the IDLE cycle after STOP, a non-empty FIFO with en=1 pops immediately. Inter-frame gap is exactly 1 clk.
- en=0 mid-frame: current frame completes; no further pops.
- Configuration inputs (baud_div, data_size, stop2, parity_type) must be held stable while busy=1. They are sampled live, with no latching.
- Data bits above N in the latched word are ignored.
- fifo_empty asserting mid-frame: ignored.

## Timing
- Reset values: tx=1, fifo_rd=0, busy=0, done=0, state=IDLE, counters=0.
- Reset mid-frame: tx returns to 1 asynchronously. The partial frame is abandoned and no done pulse is issued.
- fifo_rd is high in cycle T. tx falls and busy rises at the clk edge ending T, so tx=0 from cycle T+1.
- Bit period B = 16*(baud_div+1) clks.
- Frame length = B*(1+N+P+S), where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- done is asserted in the last cycle of the final stop bit. busy falls at the same edge at which IDLE is entered.
- All outputs are registered, with no combinational path from inputs to tx. The exception is fifo_rd, which is a registered-state-qualified function of en and fifo_empty.
- fifo_rd is never asserted when fifo_empty=1 and never for more than one cycle per frame.

## Test plan
- 8N1, baud_div=0, FIFO holds 0x55. Required: fifo_rd 1 cycle; tx = 0,1,0,1,0,1,0,1,0,1, each bit 16 clks (160 clks total); done once; busy 160 clks.
- 8E1, baud_div=3, data 0xA3. Required: bit period 64 clks; data bits LSB-first 1,1,0,0,0,1,0,1; parity bit 0; one stop bit; 704 clks total.
- 7O2, baud_div=0, data 0x7F. Required: 7 ones, parity 0 (odd), then two stop bits; 176 clks; bit 8 of the word ignored.
- Three words queued, en=1. Required: three pops; each frame separated by exactly 1 idle clk at tx=1; done pulses 3 times.
- en dropped during DATA of frame 1 with 2 words queued. Required: frame 1 completes; no second fifo_rd; tx stays 1.
- rst_n low mid-DATA. Required: tx=1, busy=0, and fifo_rd=0 immediately; no done pulse. After release with an empty FIFO: IDLE, tx=1.
